// File: rtl/mouse_pkg.sv
// Shared constants, converter state encoding and edge arithmetic for the mouse position path.
package mouse_pkg;

  localparam int DELTA_W = 9;
  localparam int WHEEL_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  // One correction step is enough because a 9-bit delta never exceeds MAX+1 when MAX >= 255.
  function automatic int sat_wrap(input int s, input int max, input logic wrap);
    if (s < 0) begin
      return wrap ? s + max + 1 : 0;
    end else if (s > max) begin
      return wrap ? s - (max + 1) : max;
    end
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per cycle.
module bin2bcd_seq
  import mouse_pkg::*;
#(
  parameter int POS_W  = 10,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [POS_W-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done
);

  conv_state_t           state, state_nxt;
  logic [3:0]            cnt;
  logic [POS_W-1:0]      sh;
  logic [4*DIGITS-1:0]   acc, acc_adj, acc_shift;
  logic                  last;

  assign last = (cnt == 4'(POS_W - 1));

  always_comb begin
    acc_adj = acc;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc[4*d +: 4] > 4'd4) acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
    end
  end

  assign acc_shift = {acc_adj[4*DIGITS-2:0], sh[POS_W-1]};

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sh    <= '0;
      acc   <= '0;
      bcd   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            sh  <= bin;
            acc <= '0;
            cnt <= '0;
          end
        end
        SHIFT: begin
          sh  <= sh << 1;
          acc <= acc_shift;
          cnt <= cnt + 4'd1;
          // Result is published on the final shift so it is already valid during DONE.
          if (last) bcd <= acc_shift;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mouse_position_tracker.sv
// Accumulates PS/2 packets into bounded X/Y and wheel counters and renders X/Y as BCD.
// Packet latency is one cycle; conversion requests coalesce into a single pending flag.
module mouse_position_tracker
  import mouse_pkg::*;
#(
  parameter int POS_W  = 10,
  parameter int X_MAX  = 639,
  parameter int Y_MAX  = 479,
  parameter int X_HOME = 320,
  parameter int Y_HOME = 240,
  parameter int WRAP   = 0,
  parameter int DIGITS = 4,
  parameter int Z_EN   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      done_tick,
  input  logic [DELTA_W-1:0]        xm,
  input  logic [DELTA_W-1:0]        ym,
  input  logic [WHEEL_W-1:0]        zm,
  output logic [POS_W-1:0]          x_pos,
  output logic [POS_W-1:0]          y_pos,
  output logic signed [7:0]         z_pos,
  output logic [4*DIGITS-1:0]       bcd_x,
  output logic [4*DIGITS-1:0]       bcd_y,
  output logic                      bcd_valid,
  output logic                      busy
);

  localparam int S_W = POS_W + 2;

  logic signed [S_W-1:0] sx, sy;
  logic [POS_W-1:0]      x_nxt, y_nxt;
  logic signed [7:0]     z_nxt;
  int                    zs;
  logic                  pending, start;
  logic                  bx_busy, by_busy, bx_done, by_done;

  // Screen Y grows downward, so an upward mouse delta is subtracted.
  assign sx    = $signed({2'b00, x_pos}) + S_W'($signed(xm));
  assign sy    = $signed({2'b00, y_pos}) - S_W'($signed(ym));
  assign x_nxt = POS_W'(sat_wrap(int'(sx), X_MAX, WRAP != 0));
  assign y_nxt = POS_W'(sat_wrap(int'(sy), Y_MAX, WRAP != 0));

  always_comb begin
    zs = int'(z_pos) + int'($signed(zm));
    if (Z_EN == 0)       z_nxt = '0;
    else if (zs > 127)   z_nxt = 8'sd127;
    else if (zs < -128)  z_nxt = 8'sh80;
    else                 z_nxt = 8'(zs);
  end

  assign busy      = bx_busy | by_busy;
  assign bcd_valid = bx_done & by_done;
  assign start     = pending & ~busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      x_pos   <= POS_W'(X_HOME);
      y_pos   <= POS_W'(Y_HOME);
      z_pos   <= '0;
      pending <= 1'b1;
    end else begin
      if (clear) begin
        x_pos <= POS_W'(X_HOME);
        y_pos <= POS_W'(Y_HOME);
        z_pos <= '0;
      end else if (done_tick) begin
        x_pos <= x_nxt;
        y_pos <= y_nxt;
        z_pos <= z_nxt;
      end
      // A new request in the snapshot cycle wins, so the fresh value gets converted next.
      if (clear || done_tick) pending <= 1'b1;
      else if (start)         pending <= 1'b0;
    end
  end

  bin2bcd_seq #(.POS_W(POS_W), .DIGITS(DIGITS)) u_conv_x (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (x_pos),
    .bcd   (bcd_x),
    .busy  (bx_busy),
    .done  (bx_done)
  );

  bin2bcd_seq #(.POS_W(POS_W), .DIGITS(DIGITS)) u_conv_y (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (y_pos),
    .bcd   (bcd_y),
    .busy  (by_busy),
    .done  (by_done)
  );

endmodule
